// File: rtl/aidc_lite_code_extract.sv
// Bit-stream extractor for AIDC-Lite: fetches a 512-bit block as eight 64-bit words,
// strips the 2-bit prefix and presents an MSB-aligned peek window to the code decoder.
module aidc_lite_code_extract #(
  parameter int unsigned DATA_SIZE = 66,
  parameter int unsigned BLK_BITS  = 512,
  parameter int unsigned BUF_SIZE  = DATA_SIZE + 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 rd_req_o,
  output logic [2:0]           rd_addr_o,
  input  logic [63:0]          rd_data_i,
  output logic                 valid_o,
  output logic [1:0]           prefix_o,
  output logic [DATA_SIZE-1:0] data_o,
  input  logic                 consume_i,
  input  logic [6:0]           size_i,
  input  logic                 eop_i,
  output logic                 done_o,
  output logic                 fail_o
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q, state_d;
  logic [BUF_SIZE-1:0] buf_q, buf_d;
  logic [7:0]          buf_cnt_q, buf_cnt_d;
  logic [3:0]          words_req_q, words_req_d;
  logic [3:0]          words_rcv_q, words_rcv_d;
  logic                pend_q, pend_d;
  logic [10:0]         consumed_q, consumed_d;
  logic [1:0]          prefix_q, prefix_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;

  logic                run;
  logic                rd_req;
  logic                valid;
  logic                fire;
  logic                illegal;
  logic                first_word;
  logic [10:0]         consumed_sum;
  logic [10:0]         consumed_base;
  logic [BUF_SIZE-1:0] buf_shift;
  logic [7:0]          cnt_shift;
  logic [BUF_SIZE-1:0] word_al;

  always_comb begin
    run    = (state_q == StRun);
    rd_req = run && (words_req_q < 4'd8) && !pend_q && (buf_cnt_q <= 8'(BUF_SIZE - 64));
    valid  = run && ((buf_cnt_q >= 8'(DATA_SIZE)) ||
                     ((words_rcv_q == 4'd8) && (buf_cnt_q != 8'd0)));
    fire   = valid && consume_i;

    // consumed+size fits in 11 bits (max 512+127), so no overflow before the compare
    consumed_sum = consumed_q + 11'(size_i);
    illegal      = fire && ((size_i > 7'(DATA_SIZE)) ||
                            ({1'b0, size_i} > buf_cnt_q) ||
                            (consumed_sum > 11'(BLK_BITS)));

    buf_shift     = fire ? (buf_q << size_i) : buf_q;
    cnt_shift     = fire ? (buf_cnt_q - {1'b0, size_i}) : buf_cnt_q;
    consumed_base = fire ? consumed_sum : consumed_q;

    // Returning word lands right after the bits still held once this cycle's consume is applied
    first_word = (words_rcv_q == 4'd0);
    word_al    = first_word ? {rd_data_i[61:0], {(BUF_SIZE - 62){1'b0}}}
                            : {rd_data_i, {(BUF_SIZE - 64){1'b0}}};
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    words_req_d = words_req_q;
    words_rcv_d = words_rcv_q;
    pend_d      = pend_q;
    consumed_d  = consumed_q;
    prefix_d    = prefix_q;
    done_d      = done_q;
    fail_d      = fail_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          buf_d       = '0;
          buf_cnt_d   = 8'd0;
          words_req_d = 4'd0;
          words_rcv_d = 4'd0;
          pend_d      = 1'b0;
          consumed_d  = 11'd0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
        end
      end
      StRun: begin
        if (illegal) begin
          state_d = StIdle;
          pend_d  = 1'b0;
          done_d  = 1'b1;
          fail_d  = 1'b1;
        end else if (fire && eop_i) begin
          // Block ends here: any in-flight word is dropped and no further reads issue
          state_d    = StIdle;
          pend_d     = 1'b0;
          done_d     = 1'b1;
          buf_d      = buf_shift;
          buf_cnt_d  = cnt_shift;
          consumed_d = consumed_base;
        end else begin
          buf_d      = buf_shift;
          buf_cnt_d  = cnt_shift;
          consumed_d = consumed_base;
          if (pend_q) begin
            pend_d      = 1'b0;
            words_rcv_d = words_rcv_q + 4'd1;
            buf_d       = buf_shift | (word_al >> cnt_shift);
            if (first_word) begin
              prefix_d   = rd_data_i[63:62];
              buf_cnt_d  = cnt_shift + 8'd62;
              consumed_d = consumed_base + 11'd2;
            end else begin
              buf_cnt_d  = cnt_shift + 8'd64;
            end
          end
          if (rd_req) begin
            words_req_d = words_req_q + 4'd1;
            pend_d      = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      buf_cnt_q   <= 8'd0;
      words_req_q <= 4'd0;
      words_rcv_q <= 4'd0;
      pend_q      <= 1'b0;
      consumed_q  <= 11'd0;
      prefix_q    <= 2'd0;
      done_q      <= 1'b1;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      words_req_q <= words_req_d;
      words_rcv_q <= words_rcv_d;
      pend_q      <= pend_d;
      consumed_q  <= consumed_d;
      prefix_q    <= prefix_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  assign rd_req_o  = rd_req;
  assign rd_addr_o = words_req_q[2:0];
  assign valid_o   = valid;
  assign data_o    = buf_q[BUF_SIZE-1 -: DATA_SIZE];
  assign prefix_o  = prefix_q;
  assign done_o    = done_q;
  assign fail_o    = fail_q;

endmodule

// File: tb/tb_aidc_lite_code_extract.sv
// Scoreboard bench for aidc_lite_code_extract: a memory responder serves reads, the
// driver pushes the expected peek window for every valid cycle, a monitor compares.
module tb_aidc_lite_code_extract;

  localparam int DS = 66;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          rd_req_o;
  logic [2:0]    rd_addr_o;
  logic [63:0]   rd_data_i;
  logic          valid_o;
  logic [1:0]    prefix_o;
  logic [DS-1:0] data_o;
  logic          consume_i;
  logic [6:0]    size_i;
  logic          eop_i;
  logic          done_o;
  logic          fail_o;

  always #5 clk = ~clk;

  aidc_lite_code_extract dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .rd_req_o  (rd_req_o),
    .rd_addr_o (rd_addr_o),
    .rd_data_i (rd_data_i),
    .valid_o   (valid_o),
    .prefix_o  (prefix_o),
    .data_o    (data_o),
    .consume_i (consume_i),
    .size_i    (size_i),
    .eop_i     (eop_i),
    .done_o    (done_o),
    .fail_o    (fail_o)
  );

  logic [63:0]   mem [8];
  int            addr_log[$];
  logic [DS-1:0] exp_q[$];
  logic [DS-1:0] exp_w;
  int            plan[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  bit            sb_on  = 1'b0;
  int            pos;
  bit            prev_req = 1'b0;
  int            prev_addr = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream bit i is block bit i+2 (prefix skipped); bits past the block read as 0.
  function automatic logic [DS-1:0] exp_win(input int p);
    logic [DS-1:0] w;
    int g;
    w = '0;
    for (int j = 0; j < DS; j++) begin
      if (p + j < 510) begin
        g = p + j + 2;
        w[DS-1-j] = mem[g / 64][63 - (g % 64)];
      end
    end
    return w;
  endfunction

  function automatic void gen_plan(input int total);
    int rem;
    int s;
    plan.delete();
    rem = total;
    while (rem > 0) begin
      s = $urandom_range((rem < DS) ? rem : DS, 0);
      plan.push_back(s);
      rem -= s;
    end
  endfunction

  function automatic void rand_mem();
    for (int i = 0; i < 8; i++) mem[i] = {$urandom, $urandom};
  endfunction

  // Block memory: data for a request appears in the following cycle.
  initial begin
    rd_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_data_i = prev_req ? mem[prev_addr] : {$urandom, $urandom};
      prev_req  = rd_req_o;
      prev_addr = int'(rd_addr_o);
      if (rd_req_o) addr_log.push_back(int'(rd_addr_o));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb_on && valid_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL window: valid_o with data %0h but no expected entry", data_o);
        end else begin
          exp_w = exp_q.pop_front();
          check("window", data_o, exp_w);
        end
      end
    end
  end

  // Drive the codes in plan[]; every valid cycle gets one expected window.
  task automatic run_block(input bit last_eop, input int idle_pct);
    int k;
    int budget;
    k = 0;
    budget = 0;
    sb_on = 1'b1;
    while (k < plan.size() && budget < 400) begin
      if (valid_o) begin
        exp_q.push_back(exp_win(pos));
        if (int'($urandom_range(99, 0)) < idle_pct) begin
          consume_i = 1'b0;
          eop_i     = 1'b0;
        end else begin
          consume_i = 1'b1;
          size_i    = 7'(plan[k]);
          eop_i     = last_eop && (k == plan.size() - 1);
          pos      += plan[k];
          k++;
        end
      end else begin
        // Must be ignored while the window is not valid
        consume_i = 1'($urandom);
        size_i    = 7'($urandom);
        eop_i     = 1'($urandom);
      end
      tick();
      budget++;
    end
    consume_i = 1'b0;
    eop_i     = 1'b0;
    size_i    = 7'd0;
    sb_on     = 1'b0;
    if (k < plan.size()) begin
      n_chk++;
      n_fail++;
      $display("FAIL block_timeout: consumed %0d of %0d codes", k, plan.size());
    end
  endtask

  task automatic do_start();
    pos = 0;
    addr_log.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; consume_i = 1'b0; size_i = 7'd0; eop_i = 1'b0;
    rand_mem();
    tick();
    tick();
    check("reset_valid", valid_o, 1'b0);
    check("reset_rd_req", rd_req_o, 1'b0);
    check("reset_rd_addr", rd_addr_o, 3'd0);
    check("reset_done", done_o, 1'b1);
    check("reset_fail", fail_o, 1'b0);
    check("reset_prefix", prefix_o, 2'd0);
    check("reset_data", data_o, '0);
    check("reset_no_reads", addr_log.size(), 0);
    rst = 1'b0;
    tick();

    // Start latency, then the full 8x63-bit block on the same data
    mem[0] = {2'b01, 62'h2AAA_AAAA_AAAA_AAAA};
    do_start();
    check("lat_c1_req", rd_req_o, 1'b1);
    check("lat_c1_addr", rd_addr_o, 3'd0);
    check("lat_c1_done", done_o, 1'b0);
    tick();
    check("lat_c2_req", rd_req_o, 1'b0);
    tick();
    check("lat_c3_req", rd_req_o, 1'b1);
    check("lat_c3_addr", rd_addr_o, 3'd1);
    tick();
    check("lat_c4_valid", valid_o, 1'b0);
    tick();
    check("lat_c5_valid", valid_o, 1'b1);
    check("lat_c5_prefix", prefix_o, 2'b01);
    check("lat_c5_data", data_o, {mem[0][61:0], mem[1][63:60]});
    check("lat_c5_done", done_o, 1'b0);
    plan.delete();
    for (int i = 0; i < 8; i++) plan.push_back(63);
    run_block(1'b1, 0);
    check("full_done", done_o, 1'b1);
    check("full_fail", fail_o, 1'b0);
    check("full_valid", valid_o, 1'b0);
    check("full_nreads", addr_log.size(), 8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++) check("full_addr", addr_log[i], i);
    check("full_sb_empty", exp_q.size(), 0);

    // Overflow: 510 consumed (prefix included), then a 10-bit code
    rand_mem();
    do_start();
    check("ovf_done_clr", done_o, 1'b0);
    gen_plan(508);
    plan.push_back(10);
    run_block(1'b0, 20);
    check("ovf_fail", fail_o, 1'b1);
    check("ovf_done", done_o, 1'b1);
    check("ovf_valid", valid_o, 1'b0);

    // Restart clears fail; reset lands on the word-0 return cycle
    mem[0][63:62] = 2'b11;
    do_start();
    check("restart_fail_clr", fail_o, 1'b0);
    check("restart_done_clr", done_o, 1'b0);
    check("restart_addr0", rd_addr_o, 3'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rand_mem();
    mem[0][63:62] = 2'b10;
    check("midrst_prefix", prefix_o, 2'd0);
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_done", done_o, 1'b1);
    tick();
    do_start();
    plan.delete();
    begin
      int sum = 0;
      int s;
      for (int i = 0; i < 12; i++) begin
        s = $urandom_range(DS, 1);
        if (sum + s <= 508) begin
          plan.push_back(s);
          sum += s;
        end
      end
    end
    run_block(1'b1, 25);
    check("midrst_new_prefix", prefix_o, 2'b10);
    check("midrst_first_addr", (addr_log.size() > 0) ? addr_log[0] : -1, 0);
    check("midrst_blk_done", done_o, 1'b1);
    check("midrst_blk_fail", fail_o, 1'b0);

    // Tail: 40 bits left after the last word, then an oversized code
    rand_mem();
    do_start();
    gen_plan(470);
    run_block(1'b0, 10);
    for (int i = 0; i < 20 && !valid_o; i++) tick();
    check("tail_valid", valid_o, 1'b1);
    check("tail_zero_fill", data_o[25:0], 26'd0);
    check("tail_data", data_o, exp_win(470));
    plan.delete();
    plan.push_back(41);
    run_block(1'b0, 0);
    check("tail_fail", fail_o, 1'b1);
    check("tail_done", done_o, 1'b1);
    check("sb_empty", exp_q.size(), 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aidc_lite_code_extract.md
# aidc_lite_code_extract

Bit-stream extractor for the AIDC-Lite decompression path. It reads one packed 512-bit compressed block as eight 64-bit words from block memory at addresses 0..7. It strips the 2-bit prefix and presents a DATA_SIZE-bit MSB-aligned peek window to the downstream code decoder. The decoder consumes a variable number of bits per cycle, and the block refills its internal bit buffer from memory as space frees up.

## Interface
- DATA_SIZE, 66, peek window width in bits; also the maximum bits consumable per cycle.
- BLK_BITS, 512, block size in bits; total consumption beyond this is a failure.
- BUF_SIZE, DATA_SIZE+64, bit-buffer capacity.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin extracting a new block; honoured only in IDLE.
- rd_req_o  out  1  block-memory read request.
- rd_addr_o  out  3  word address for the read.
- rd_data_i  in  64  read data; valid exactly one cycle after rd_req_o.
- valid_o  out  1  peek window valid.
- prefix_o  out  2  prefix of the current block; bits [63:62] of word 0.
- data_o  out  DATA_SIZE  next stream bits, MSB = oldest; bits past the buffer fill read 0.
- consume_i  in  1  decoder consumes size_i bits; ignored unless valid_o.
- size_i  in  7  bits consumed this cycle (0..DATA_SIZE).
- eop_i  in  1  qualified with consume_i; this is the last code of the block.
- done_o  out  1  level; block finished or idle.
- fail_o  out  1  sticky error for the current block.

## Operation
- **States:** IDLE and RUN.
- **Reset:** enter IDLE.
  - valid_o=0, rd_req_o=0, rd_addr_o=0, prefix_o=0, data_o=0.
  - done_o=1, fail_o=0.
  - Internal counters cleared; pending-read flag cleared, so in-flight read data is discarded.
- **IDLE + start_i:** go to RUN.
  - Clear buf_cnt, word counters, consumed count and fail_o.
  - done_o goes to 0.
- **start_i in RUN:** ignored.
- **Read issue:** rd_req_o = RUN & (words_req<8) & !pend & (buf_cnt <= BUF_SIZE-64).
  - rd_addr_o = words_req.
  - Each request increments words_req and sets pend.
  - At most one read is outstanding.
- **Word return:** the cycle after a request, rd_data_i is appended at bit offset buf_cnt from the MSB (offset taken after any same-cycle consume shift), and pend is cleared.
  - Word 0 only: bits [63:62] go to prefix_o; the remaining 62 bits are appended; consumed is set to 2.
- **Validity:** valid_o = RUN & (buf_cnt >= DATA_SIZE | (words_rcv==8 & buf_cnt>0)).
  - valid_o, data_o and rd_req_o depend on registered state only.
- **Consume** (valid_o & consume_i):
  - Buffer shifts left by size_i with zero fill.
  - buf_cnt -= size_i; consumed += size_i.
- **Counter widths:**
  - consumed: 11 bits, compared unsigned against BLK_BITS.
  - buf_cnt: 8 bits.
- **Fail:** a consume with size_i > DATA_SIZE, size_i > buf_cnt, or consumed+size_i > BLK_BITS sets fail_o=1 and done_o=1, and returns to IDLE.
- **eop_i with a legal consume:** done_o=1, fail_o unchanged, return to IDLE.
  - Unread words are not fetched.
  - Outstanding return data is discarded.
- **Simultaneous events:** a word return and a consume in the same cycle are both applied; the resulting buf_cnt never exceeds BUF_SIZE.

## Timing
- start_i sampled in cycle 0 gives:
  - RUN and rd_req_o (addr 0) in cycle 1; data in cycle 2.
  - buf_cnt=62 in cycle 3, rd_req_o (addr 1) in cycle 3.
  - buf_cnt=126 and valid_o=1 in cycle 5.
- Refill rate is at most one word per 2 cycles. The decoder sees valid_o=0 whenever buf_cnt < DATA_SIZE before all words are received; no bits are lost.
- Consume effects appear in data_o the next cycle.
- done_o and fail_o update one cycle after the terminating consume.

## Test plan
- **Reset:** hold rst 2 cycles -> valid_o=0, rd_req_o=0, done_o=1, fail_o=0, prefix_o=0; no reads.
- **Start latency:** word0={2'b01, 62'h2AAA...}, start_i at cycle 0 -> rd_addr 0 in cycle 1, rd_addr 1 in cycle 3; cycle 5: valid_o=1, prefix_o=01, data_o = {word0[61:0], word1[63:60]}, done_o=0.
- **Full block:** random data, consume 63 bits per valid cycle, 8 codes with eop_i on the 8th (2+504=506 bits) -> addresses 0..7 read once each in order, reconstructed stream matches memory, done_o=1, fail_o=0.
- **Overflow:** consume sizes totalling 510 bits, then size_i=10 -> fail_o=1, done_o=1 next cycle; a following start_i clears both.
- **Tail:** after all 8 words, buf_cnt=40 -> valid_o=1, data_o low 26 bits = 0; consume size_i=41 -> fail_o=1.
- **Reset mid-run:** assert rst in the cycle rd_data_i returns -> data ignored; a new start_i reads from addr 0 with prefix_o taken from the new word 0.
